// File: rtl/nic_mem_pkg.sv
// Package: nic_mem_pkg
// Purpose: shared definitions for the NIC packet buffer RAM.
//   - clear-engine FSM state encoding
//   - byte-lane count helper
//   - per-lane collision merge used when both ports write one address
package nic_mem_pkg;

  // Clear-engine FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Number of byte lanes in a word of the given width
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Byte written to a lane when both ports target the same address in one
  // cycle. Port A wins on lanes both ports enable; otherwise the single
  // enabling port supplies the byte.
  function automatic logic [7:0] lane_merge(input logic       be_a,
                                            input logic       be_b,
                                            input logic [7:0] d_a,
                                            input logic [7:0] d_b);
    logic [7:0] v_out;
    if (be_a) begin
      v_out = d_a;
    end else if (be_b) begin
      v_out = d_b;
    end else begin
      v_out = 8'h00;
    end
    return v_out;
  endfunction

endpackage

// File: rtl/pkt_buf_req.sv
// Module: pkt_buf_req
// Purpose: toggle-handshake front end for one port of the packet buffer.
//   Detects a pending request (i_en differs from the last serviced value),
//   fires when granted, and registers the acknowledge and the read data.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   i_en     request toggle from the requester
//   i_wr     1 = write, 0 = read
//   i_be     byte-lane write enables
//   i_grant  RAM available to service this cycle
//   i_rdata  current (pre-write) RAM word at the request address
//   o_fire   request serviced at this edge
//   o_we     per-lane write strobes for this edge
//   o_ack    acknowledge toggle (follows i_en once serviced)
//   o_dout   registered read data
import nic_mem_pkg::*;

module pkt_buf_req #(
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_wr,
  input  logic [BE_W-1:0]   i_be,
  input  logic              i_grant,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_fire,
  output logic [BE_W-1:0]   o_we,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_dout
);

  logic r_en_seen;
  logic w_pend;

  assign w_pend = i_en ^ r_en_seen;
  assign o_fire = w_pend & i_grant;
  assign o_we   = {BE_W{o_fire & i_wr}} & i_be;

  // Capture the serviced toggle, acknowledge it and latch the read word
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_en_seen <= 1'b0;
      o_ack     <= 1'b0;
      o_dout    <= {DATA_W{1'b0}};
    end else if (o_fire) begin
      r_en_seen <= i_en;
      o_ack     <= i_en;
      o_dout    <= i_rdata;
    end else begin
      r_en_seen <= r_en_seen;
      o_ack     <= o_ack;
      o_dout    <= o_dout;
    end
  end

endmodule

// File: rtl/pkt_buf_mem.sv
// Module: pkt_buf_mem
// Purpose: dual-port packet buffer RAM (port A = MAC side, port B = host
//   side) on one clock, with toggle request/acknowledge per port, byte-lane
//   write enables, read-first collisions and a sweeping clear engine.
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   CLR / BUSY            start clear sweep (idle only) / sweep in progress
//   A_EN/B_EN             request toggles
//   A_WR/B_WR             1 = write, 0 = read
//   A_BE/B_BE             byte-lane write enables
//   A_ADDR/B_ADDR         word addresses
//   A_DIN/B_DIN           write data
//   A_DOUT/B_DOUT         registered read data (pre-write contents)
//   A_ACK/B_ACK           completion toggles
import nic_mem_pkg::*;

module pkt_buf_mem #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 9,
  parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}}
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CLR,
  output logic                BUSY,
  input  logic                A_EN,
  input  logic                A_WR,
  input  logic [DATA_W/8-1:0] A_BE,
  input  logic [ADDR_W-1:0]   A_ADDR,
  input  logic [DATA_W-1:0]   A_DIN,
  output logic [DATA_W-1:0]   A_DOUT,
  output logic                A_ACK,
  input  logic                B_EN,
  input  logic                B_WR,
  input  logic [DATA_W/8-1:0] B_BE,
  input  logic [ADDR_W-1:0]   B_ADDR,
  input  logic [DATA_W-1:0]   B_DIN,
  output logic [DATA_W-1:0]   B_DOUT,
  output logic                B_ACK
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_grant;
  logic              w_a_fire;
  logic              w_b_fire;
  logic [BE_W-1:0]   w_a_we;
  logic [BE_W-1:0]   w_b_we;
  logic [DATA_W-1:0] w_a_rdata;
  logic [DATA_W-1:0] w_b_rdata;

  // Requests are held off during a sweep and at a reset edge
  assign w_grant = (r_state == ST_IDLE) && RST_N;

  pkt_buf_req #(.DATA_W(DATA_W), .BE_W(BE_W)) u_req_a (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (A_EN),
    .i_wr    (A_WR),
    .i_be    (A_BE),
    .i_grant (w_grant),
    .i_rdata (w_a_rdata),
    .o_fire  (w_a_fire),
    .o_we    (w_a_we),
    .o_ack   (A_ACK),
    .o_dout  (A_DOUT)
  );

  pkt_buf_req #(.DATA_W(DATA_W), .BE_W(BE_W)) u_req_b (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (B_EN),
    .i_wr    (B_WR),
    .i_be    (B_BE),
    .i_grant (w_grant),
    .i_rdata (w_b_rdata),
    .o_fire  (w_b_fire),
    .o_we    (w_b_we),
    .o_ack   (B_ACK),
    .o_dout  (B_DOUT)
  );

  // One RAM array per byte lane so each lane maps onto its own memory.
  // Reads are taken before the write lands, which gives read-first
  // behaviour on every collision.
  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    assign w_a_rdata[8*g +: 8] = r_mem[A_ADDR];
    assign w_b_rdata[8*g +: 8] = r_mem[B_ADDR];

    // Lane write: clear sweep, merged same-address write, or independent writes
    always_ff @(posedge CLK) begin
      if (RST_N && (r_state == ST_CLEAR)) begin
        r_mem[r_cnt] <= CLR_VAL[8*g +: 8];
      end else if ((A_ADDR == B_ADDR) && (w_a_we[g] || w_b_we[g])) begin
        r_mem[A_ADDR] <= lane_merge(w_a_we[g], w_b_we[g],
                                    A_DIN[8*g +: 8], B_DIN[8*g +: 8]);
      end else begin
        if (w_a_we[g]) begin
          r_mem[A_ADDR] <= A_DIN[8*g +: 8];
        end
        if (w_b_we[g]) begin
          r_mem[B_ADDR] <= B_DIN[8*g +: 8];
        end
      end
    end
  end

  // Clear engine: one address per cycle; the counter wraps to zero on exit
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      BUSY    <= 1'b0;
      r_cnt   <= {ADDR_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CLR) begin
            r_state <= ST_CLEAR;
            BUSY    <= 1'b1;
            r_cnt   <= {ADDR_W{1'b0}};
          end else begin
            r_state <= ST_IDLE;
            BUSY    <= 1'b0;
            r_cnt   <= r_cnt;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (r_cnt == {ADDR_W{1'b1}}) begin
            r_state <= ST_IDLE;
            BUSY    <= 1'b0;
          end else begin
            r_state <= ST_CLEAR;
            BUSY    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          BUSY    <= 1'b0;
          r_cnt   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_buf_mem.sv
// Testbench for pkt_buf_mem. Two instances share all inputs: a 512-word one
// (ADDR_W=9) for the access/collision cases and a 16-word one (ADDR_W=4) for
// the clear-sweep cases; 'sel' picks which instance's outputs are observed.
module tb_pkt_buf_mem;

  localparam logic [31:0] CV = 32'hA5A5_5A5A;

  logic        CLK, RST_N, CLR;
  logic        A_EN, A_WR, B_EN, B_WR;
  logic [3:0]  A_BE, B_BE;
  logic [8:0]  A_ADDR, B_ADDR;
  logic [31:0] A_DIN, B_DIN;

  logic        g_busy, g_a_ack, g_b_ack, s_busy, s_a_ack, s_b_ack;
  logic [31:0] g_a_dout, g_b_dout, s_a_dout, s_b_dout;

  logic        sel;
  logic        m_busy, m_a_ack, m_b_ack;
  logic [31:0] m_a_dout, m_b_dout;

  assign m_busy   = sel ? s_busy   : g_busy;
  assign m_a_ack  = sel ? s_a_ack  : g_a_ack;
  assign m_b_ack  = sel ? s_b_ack  : g_b_ack;
  assign m_a_dout = sel ? s_a_dout : g_a_dout;
  assign m_b_dout = sel ? s_b_dout : g_b_dout;

  pkt_buf_mem #(.DATA_W(32), .ADDR_W(9), .CLR_VAL(CV)) u_big (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .BUSY(g_busy),
    .A_EN(A_EN), .A_WR(A_WR), .A_BE(A_BE), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
    .A_DOUT(g_a_dout), .A_ACK(g_a_ack),
    .B_EN(B_EN), .B_WR(B_WR), .B_BE(B_BE), .B_ADDR(B_ADDR), .B_DIN(B_DIN),
    .B_DOUT(g_b_dout), .B_ACK(g_b_ack)
  );

  pkt_buf_mem #(.DATA_W(32), .ADDR_W(4), .CLR_VAL(CV)) u_small (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .BUSY(s_busy),
    .A_EN(A_EN), .A_WR(A_WR), .A_BE(A_BE), .A_ADDR(A_ADDR[3:0]), .A_DIN(A_DIN),
    .A_DOUT(s_a_dout), .A_ACK(s_a_ack),
    .B_EN(B_EN), .B_WR(B_WR), .B_BE(B_BE), .B_ADDR(B_ADDR[3:0]), .B_DIN(B_DIN),
    .B_DOUT(s_b_dout), .B_ACK(s_b_ack)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected read data per port, pushed on drive, popped on ACK
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  string       qa_tag[$];
  string       qb_tag[$];

  task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic wr, input logic [3:0] be, input logic [8:0] addr,
                         input logic [31:0] din, input bit chk, input logic [31:0] exp,
                         input string tag);
    A_WR = wr; A_BE = be; A_ADDR = addr; A_DIN = din;
    A_EN = ~A_EN;
    if (chk) begin
      qa.push_back(exp);
      qa_tag.push_back(tag);
    end
  endtask

  task automatic drive_b(input logic wr, input logic [3:0] be, input logic [8:0] addr,
                         input logic [31:0] din, input bit chk, input logic [31:0] exp,
                         input string tag);
    B_WR = wr; B_BE = be; B_ADDR = addr; B_DIN = din;
    B_EN = ~B_EN;
    if (chk) begin
      qb.push_back(exp);
      qb_tag.push_back(tag);
    end
  endtask

  // Wait (bounded) until both ACKs follow their ENs, then score any reads
  task automatic wait_acks(input int budget, output int cyc);
    bit          done;
    logic [31:0] e;
    string       t;
    done = 1'b0;
    cyc  = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge CLK);
      cyc++;
      done = (m_a_ack == A_EN) && (m_b_ack == B_EN);
    end
    tb_check("ack_timeout", {31'b0, done}, 32'd1);
    if (qa.size() > 0) begin
      e = qa.pop_front(); t = qa_tag.pop_front();
      tb_check(t, m_a_dout, e);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front(); t = qb_tag.pop_front();
      tb_check(t, m_b_dout, e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int busy_cnt;
    int held_bad;

    RST_N = 1'b0; CLR = 1'b0; sel = 1'b0;
    A_EN = 1'b0; A_WR = 1'b0; A_BE = 4'h0; A_ADDR = 9'h0; A_DIN = 32'h0;
    B_EN = 1'b0; B_WR = 1'b0; B_BE = 4'h0; B_ADDR = 9'h0; B_DIN = 32'h0;

    // 1: reset state, then idle with EN held low
    repeat (3) @(negedge CLK);
    tb_check("rst_a_dout", m_a_dout, 32'h0);
    tb_check("rst_b_dout", m_b_dout, 32'h0);
    tb_check("rst_a_ack", {31'b0, m_a_ack}, 32'd0);
    tb_check("rst_b_ack", {31'b0, m_b_ack}, 32'd0);
    tb_check("rst_busy", {31'b0, m_busy}, 32'd0);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    tb_check("idle_a_ack", {31'b0, m_a_ack}, 32'd0);
    tb_check("idle_b_ack", {31'b0, m_b_ack}, 32'd0);

    // 2: full write then read, one-cycle latency each
    drive_a(1'b1, 4'hF, 9'h1F5, 32'hDEAD_BEEF, 1'b0, 32'h0, "");
    wait_acks(8, cyc);
    tb_check("t2_wr_lat", cyc, 32'd1);
    drive_a(1'b0, 4'h0, 9'h1F5, 32'h0, 1'b1, 32'hDEAD_BEEF, "t2_rd");
    wait_acks(8, cyc);
    tb_check("t2_rd_lat", cyc, 32'd1);

    // 3: partial byte-lane write; the write itself returns pre-write data
    drive_a(1'b1, 4'hF, 9'h010, 32'h1122_3344, 1'b0, 32'h0, "");
    wait_acks(8, cyc);
    drive_a(1'b1, 4'b0101, 9'h010, 32'hAABB_CCDD, 1'b1, 32'h1122_3344, "t3_wr_old");
    wait_acks(8, cyc);
    drive_a(1'b0, 4'h0, 9'h010, 32'h0, 1'b1, 32'h11BB_33DD, "t3_rd");
    wait_acks(8, cyc);

    // 4: read-first collision, then double write with lane merge
    drive_a(1'b1, 4'hF, 9'h020, 32'h0, 1'b0, 32'h0, "");
    wait_acks(8, cyc);
    drive_a(1'b1, 4'hF, 9'h020, 32'h1234_5678, 1'b0, 32'h0, "");
    drive_b(1'b0, 4'h0, 9'h020, 32'h0, 1'b1, 32'h0, "t4_b_rdfirst");
    wait_acks(8, cyc);
    drive_a(1'b1, 4'h1, 9'h020, 32'h0000_00FF, 1'b0, 32'h0, "");
    drive_b(1'b1, 4'h3, 9'h020, 32'h0000_AB00, 1'b1, 32'h1234_5678, "t4_b_wr_old");
    wait_acks(8, cyc);
    drive_a(1'b0, 4'h0, 9'h020, 32'h0, 1'b1, 32'h1234_ABFF, "t4_merge");
    wait_acks(8, cyc);

    // 5: 16-word instance, full clear with a read held off during the sweep
    sel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 4'hF, 9'(i), 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0, "");
      wait_acks(8, cyc);
    end
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    busy_cnt = 0;
    held_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (!m_busy) break;
      busy_cnt++;
      if (busy_cnt == 2) begin
        drive_b(1'b0, 4'h0, 9'h003, 32'h0, 1'b1, CV, "t5_b_cleared");
      end else if (busy_cnt > 2 && m_b_ack == B_EN) begin
        held_bad++;
      end
      @(negedge CLK);
    end
    tb_check("t5_busy_cycles", busy_cnt, 32'd16);
    tb_check("t5_ack_held", held_bad, 32'd0);
    wait_acks(8, cyc);
    tb_check("t5_after_busy_lat", cyc, 32'd1);

    // 6: reset in the 6th busy cycle leaves only addresses 0..4 cleared
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 4'hF, 9'(i), 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0, "");
      wait_acks(8, cyc);
    end
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    repeat (5) @(negedge CLK);
    tb_check("t6_busy_before_rst", {31'b0, m_busy}, 32'd1);
    RST_N = 1'b0; A_EN = 1'b0; B_EN = 1'b0;
    @(negedge CLK);
    tb_check("t6_busy_after_rst", {31'b0, m_busy}, 32'd0);
    tb_check("t6_a_dout_rst", m_a_dout, 32'h0);
    tb_check("t6_a_ack_rst", {31'b0, m_a_ack}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b0, 4'h0, 9'(i), 32'h0, 1'b1,
              (i < 5) ? CV : (32'hC0DE_0000 + 32'(i)), $sformatf("t6_rd%0d", i));
      wait_acks(8, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
